// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 8 data bits + odd parity + stop, ACK check.
// Define PS2_TX_TIMEOUT_EN to add a watchdog from SHIFT entry until the bus returns to idle.
module ps2_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);
    typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE} state_t;

    localparam logic [20:0] INHIBIT_LAST = 21'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [20:0] TIMEOUT_LAST = 21'(TIMEOUT_CYCLES - 1);
`endif

    state_t      state, state_nxt;
    logic [20:0] cnt, cnt_nxt;
    logic [8:0]  shreg, shreg_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic        data_oe_r, data_oe_nxt;
    logic        ack_ok, ack_ok_nxt;
    logic        done_r, done_nxt;
    logic        err_r, err_nxt;
    logic        clk_s1, clk_s2, clk_s3;
    logic        data_s1, data_s2;
    logic        fall;

    // Synchronisers idle high so a reset never looks like a falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall = clk_s3 & ~clk_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            data_oe_r <= 1'b0;
            ack_ok    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            data_oe_r <= data_oe_nxt;
            ack_ok    <= ack_ok_nxt;
            done_r    <= done_nxt;
            err_r     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        data_oe_nxt = data_oe_r;
        ack_ok_nxt  = ack_ok;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_nxt = INHIBIT;
                    cnt_nxt   = '0;
                    shreg_nxt = {~^tx_data, tx_data};
                end
            end
            INHIBIT: begin
                if (cnt == INHIBIT_LAST) state_nxt = START;
                else                     cnt_nxt   = cnt + 21'd1;
            end
            START: begin
                state_nxt   = SHIFT;
                bit_cnt_nxt = '0;
                data_oe_nxt = 1'b1;
                cnt_nxt     = '0;
            end
            // Bits change only after a detected fall, so data is stable while the device clock is low
            SHIFT: begin
                if (fall) begin
                    if (bit_cnt == 4'd9) begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = ACK;
                    end else begin
                        data_oe_nxt = ~shreg[0];
                        shreg_nxt   = {1'b1, shreg[8:1]};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    ack_ok_nxt = ~data_s2;
                    state_nxt  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s2 && data_s2) begin
                    state_nxt = IDLE;
                    done_nxt  = ack_ok;
                    err_nxt   = ~ack_ok;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (state == SHIFT || state == ACK || state == WAIT_IDLE) begin
            if (cnt == TIMEOUT_LAST) begin
                state_nxt   = IDLE;
                data_oe_nxt = 1'b0;
                done_nxt    = 1'b0;
                err_nxt     = 1'b1;
            end else begin
                cnt_nxt = cnt + 21'd1;
            end
        end
`endif
    end

    assign ps2_clk_oe  = (state == INHIBIT) || (state == START);
    assign ps2_data_oe = (state == START) || ((state == SHIFT) && data_oe_r);
    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign tx_done     = done_r;
    assign tx_err      = err_r;
endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to a keyboard over the bidirectional ps2_clk/ps2_data lines. It runs the PS/2 host request sequence: clock inhibit, request-to-send, then shifts out 8 data bits LSB-first, odd parity and stop, and checks the device ACK. It sits beside the PS/2 scan-code receiver on the same two pins. Pad-level open-drain drivers are instantiated outside; this block only produces drive-low enables.

## Interface
- INHIBIT_CYCLES, 10000: clk cycles ps2_clk is held low before request-to-send (≥100 µs at 100 MHz).
- TIMEOUT_CYCLES, 2000000: clk cycles allowed from clock release to bus idle (20 ms at 100 MHz); only used with the timeout feature.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin level.
- ps2_data  in  1  raw PS/2 data pin level.
- ps2_clk_oe  out  1  1 = pull ps2_clk low, 0 = release.
- ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release.
- tx_data  in  8  byte to send, sampled on acceptance.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE; the receiver ignores frames while busy.
- tx_done  out  1  one-cycle pulse: byte sent and ACK seen.
- tx_err  out  1  one-cycle pulse: missing ACK or timeout.

## Operation
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, tx_done=0, tx_err=0. The input synchronisers reset to 1, and the state resets to IDLE.
- ps2_clk and ps2_data each pass through a 2-flop synchroniser. A falling edge is detected when the previous synced clock is 1 and the current one is 0 (3 flops total on the clock).
- On acceptance, the block latches {parity, tx_data} into a 9-bit shift register. parity = ~^tx_data, so the total count of ones is odd.
- States:
  - IDLE: both oe=0. On accept, go to INHIBIT and clear the cycle counter.
  - INHIBIT: clk_oe=1, data_oe=0. After INHIBIT_CYCLES cycles, go to START.
  - START: clk_oe=1, data_oe=1 (start bit) for exactly 1 cycle, then go to SHIFT with bit_cnt=0.
  - SHIFT: clk_oe=0. On each ps2_clk falling edge, bit_cnt 0–8 drives the next bit (data_oe = ~bit) and bit_cnt increments. At bit_cnt=9 the block releases data (stop bit), sets data_oe=0 and goes to ACK.
  - ACK: on the next falling edge, the block samples synced ps2_data: 0 means ack_ok=1, 1 means ack_ok=0. Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced ps2_clk=1 and ps2_data=1. Then pulse tx_done if ack_ok, else pulse tx_err, and return to IDLE.
- tx_valid while not ready is ignored; the byte is not queued.
- ps2_data_oe changes only in the cycle after a detected falling edge, so data is stable while the device's clock is low.

## Timing
- Accept cycle N: INHIBIT starts at N+1 with ps2_clk_oe=1 at N+1.
- START runs at cycle N+1+INHIBIT_CYCLES. ps2_clk_oe drops to 0 one cycle later.
- Falling-edge-to-data-change latency is 3 clk cycles: 2 synchroniser cycles + 1 register cycle.
- tx_done/tx_err assert the cycle after bus idle is seen and last exactly 1 cycle; tx_ready rises in the same cycle.
- rst_n low at any point immediately sets both oe=0 and aborts the frame. No tx_done or tx_err is issued.
- A device-generated falling edge during INHIBIT or START is ignored.

## Configuration
- PS2_TX_TIMEOUT_EN defined: a 21-bit watchdog counts from entry to SHIFT. If it reaches TIMEOUT_CYCLES before leaving WAIT_IDLE, the block sets both oe=0, pulses tx_err and goes to IDLE.
- PS2_TX_TIMEOUT_EN undefined: there is no watchdog, and the FSM waits indefinitely for device clocks. tx_err comes only from a missing ACK.

## Test plan
- Send 0xED with the device model clocking at a 60 µs period and ACKing. Bits at the rising edges must be 1,0,1,1,0,1,1,1, parity 1, stop 1. Expect tx_done=1 for 1 cycle and tx_err=0.
- Send 0x01. Data bits must be 1,0,0,0,0,0,0,0 with parity 0. After the ACK, tx_done pulses.
- Send 0xFF with the device holding data high at the 11th falling edge. Expect tx_err pulse, tx_done=0, back to IDLE with tx_ready=1.
- With INHIBIT_CYCLES=100, ps2_clk_oe must be high for exactly 100 cycles, then exactly 1 cycle with both oe=1, then clk_oe=0.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYCLES=5000, the device stops clocking after 4 edges. tx_err must pulse 5000 cycles after START exit, and both oe must be 0.
- Assert rst_n low mid-SHIFT (after 5 edges). Both oe must go 0 asynchronously; after release, expect tx_ready=1 and no done or err pulse.
